// File: rtl/enable_strobe_pacer.sv
// enable_strobe_pacer
//   Feeds the enable-gated register bank. Bytes come in on a valid/ready
//   stream and are buffered in a small FIFO. They leave as out_data with a
//   single-cycle out_en strobe. After each strobe the pacer inserts `gap`
//   idle cycles. out_data only changes on a strobe edge, so between strobes
//   the downstream registers see a stable input.
//
//   Optional feature: define PACER_STRB_CNT_EN to add the 16-bit strb_cnt
//   output. It is a wrapping count of issued strobes, cleared only by reset.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   upstream byte valid
//   in_data   in   upstream byte
//   in_ready  out  FIFO can accept (combinational: not full and not flushing)
//   gap       in   idle cycles after each strobe, sampled when a byte is popped
//   flush     in   synchronous clear of FIFO and pacer (out_data holds)
//   out_data  out  registered byte to the downstream bank
//   out_en    out  registered one-cycle strobe qualifying out_data
//   level     out  registered FIFO occupancy
//   strb_cnt  out  strobes issued (only with PACER_STRB_CNT_EN)
//
// Pacer states
//   state | meaning
//   IDLE  | pop the head and strobe whenever the FIFO holds data
//   GAP   | count down gap_cnt; back to IDLE once it reaches 1
module enable_strobe_pacer #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic [GAP_W-1:0]       gap,
  input  logic                   flush,
  output logic [7:0]             out_data,
  output logic                   out_en,
  output logic [$clog2(DEPTH):0] level
`ifdef PACER_STRB_CNT_EN
  ,
  output logic [15:0]            strb_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, GAP} state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       mem [DEPTH];
  logic             push, pop, out_en_nxt;

  // No bypass: a pop in the same cycle does not free a slot for the
  // incoming byte, so readiness depends only on the registered level.
  assign in_ready = (level != FULL_LVL) && !flush;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    out_en_nxt  = 1'b0;
    if (flush) begin
      state_nxt   = IDLE;
      gap_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            pop        = 1'b1;
            out_en_nxt = 1'b1;
            // gap == 0 stays in IDLE, which gives one strobe per cycle
            if (gap != '0) begin
              gap_cnt_nxt = gap;
              state_nxt   = GAP;
            end
          end
        end
        GAP: begin
          gap_cnt_nxt = gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset. Stale entries are unreachable once level is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 8'h00;
      out_en   <= 1'b0;
    end else begin
      out_en <= out_en_nxt;
      if (pop) out_data <= mem[rd_ptr];
    end
  end

`ifdef PACER_STRB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   strb_cnt <= 16'h0000;
    else if (pop) strb_cnt <= strb_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_enable_strobe_pacer.sv
// Testbench for enable_strobe_pacer. Expected bytes are queued when they are
// pushed. A monitor on the falling edge pops one expected byte for every
// strobe it sees. Between strobes it checks that out_data holds the last
// expected byte.
module tb_enable_strobe_pacer;
  localparam int DEPTH = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [GAP_W-1:0] gap;
  logic             flush;
  logic [7:0]       out_data;
  logic             out_en;
  logic [2:0]       level;
`ifdef PACER_STRB_CNT_EN
  logic [15:0]      strb_cnt;
`endif

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] sb_q[$];
  int         strb_q[$];
  logic [7:0] last_exp = 8'h00;

  enable_strobe_pacer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .gap(gap), .flush(flush), .out_data(out_data),
    .out_en(out_en), .level(level)
`ifdef PACER_STRB_CNT_EN
    , .strb_cnt(strb_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp = 8'h00;
    end else if (out_en) begin
      strb_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data %0h expected no strobe (cycle %0d)", out_data, cyc);
      end else begin
        last_exp = sb_q.pop_front();
        chk("strobe_data", 32'(out_data), 32'(last_exp));
      end
    end else begin
      chk("data_hold", 32'(out_data), 32'(last_exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    sb_q.push_back(b);
    tick();
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (sb_q.size() != 0 && k < n) begin
      tick();
      k++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         peak;
    int         pushed;
    int         guard;
    logic       saw_full;
    logic [7:0] nxt;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; gap = '0; flush = 1'b0;
    #2;
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_en",   32'(out_en),   32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single push: strobe one cycle after the push edge
    push_byte(8'hA5);
    in_valid = 1'b0;
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_no_strobe_yet",    32'(out_en), 32'd0);
    tick();
    chk("t1_strobe",      32'(out_en),   32'd1);
    chk("t1_data",        32'(out_data), 32'hA5);
    chk("t1_level_empty", 32'(level),    32'd0);
    tick();
    chk("t1_strobe_end",  32'(out_en),   32'd0);
    chk("t1_data_holds",  32'(out_data), 32'hA5);

    // Pacing with gap = 3
    gap = 4'd3;
    tick();
    strb_q.delete();
    peak = 0;
    for (int i = 1; i <= 3; i++) begin
      push_byte(8'(i));
      if (int'(level) > peak) peak = int'(level);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    chk("t2_strobe_count", 32'(strb_q.size()), 32'd3);
    if (strb_q.size() == 3) begin
      chk("t2_spacing_a", 32'(strb_q[1] - strb_q[0]), 32'd4);
      chk("t2_spacing_b", 32'(strb_q[2] - strb_q[1]), 32'd4);
    end
    chk("t2_level_peak", 32'(peak), 32'd2);

    // Back-to-back with gap = 0
    gap = 4'd0;
    tick();
    strb_q.delete();
    push_byte(8'h04);
    push_byte(8'h05);
    push_byte(8'h06);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t2_b2b_count", 32'(strb_q.size()), 32'd3);
    if (strb_q.size() == 3) begin
      chk("t2_b2b_a", 32'(strb_q[1] - strb_q[0]), 32'd1);
      chk("t2_b2b_b", 32'(strb_q[2] - strb_q[1]), 32'd1);
    end

    // Full FIFO with a long gap
    gap = 4'd15;
    nxt = 8'h10; pushed = 0; guard = 0; saw_full = 1'b0;
    in_valid = 1'b1;
    while (pushed < 8 && guard < 300) begin
      in_data = nxt;
      chk("t3_ready_vs_level", 32'(in_ready), 32'(level != 3'd4));
      if (level == 3'd4) saw_full = 1'b1;
      if (in_ready) begin
        sb_q.push_back(nxt);
        nxt++;
        pushed++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("t3_pushed", 32'(pushed), 32'd8);
    chk("t3_saw_full", 32'(saw_full), 32'd1);
    wait_drain(200);
    repeat (20) tick();

    // Flush during GAP with three bytes queued
    gap = 4'd3;
    strb_q.delete();
    push_byte(8'h20);
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    in_valid = 1'b0;
    chk("t4_level_before_flush", 32'(level), 32'd3);
    flush = 1'b1;
    #1;
    chk("t4_ready_in_flush", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    sb_q.delete();
    chk("t4_level_flushed", 32'(level),    32'd0);
    chk("t4_out_en_flushed", 32'(out_en),  32'd0);
    chk("t4_data_kept",     32'(out_data), 32'h20);
    repeat (8) tick();
    chk("t4_no_more_strobes", 32'(strb_q.size()), 32'd1);
    push_byte(8'h24);
    in_valid = 1'b0;
    chk("t4_not_yet", 32'(out_en), 32'd0);
    tick();
    chk("t4_post_flush_strobe", 32'(out_en),   32'd1);
    chk("t4_post_flush_data",   32'(out_data), 32'h24);
    repeat (6) tick();

    // Async reset during GAP with two bytes queued
    push_byte(8'h30);
    push_byte(8'h31);
    push_byte(8'h32);
    in_valid = 1'b0;
    chk("t5_level_before_rst", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data",  32'(out_data), 32'h00);
    chk("t5_rst_en",    32'(out_en),   32'd0);
    chk("t5_rst_level", 32'(level),    32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    strb_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_strobe_after_rst", 32'(strb_q.size()), 32'd0);
    push_byte(8'h33);
    in_valid = 1'b0;
    tick();
    chk("t5_new_strobe", 32'(out_en),   32'd1);
    chk("t5_new_data",   32'(out_data), 32'h33);
    repeat (6) tick();

`ifdef PACER_STRB_CNT_EN
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("t6_cnt_rst", 32'(strb_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    gap = 4'd0;
    tick();
    for (int i = 0; i < 65535; i++) push_byte(8'(i));
    in_valid = 1'b0;
    tick(); tick();
    chk("t6_cnt_ffff", 32'(strb_cnt), 32'hFFFF);
    push_byte(8'h5A);
    push_byte(8'hC3);
    in_valid = 1'b0;
    tick(); tick();
    chk("t6_cnt_wrapped", 32'(strb_cnt), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("t6_cnt_after_flush", 32'(strb_cnt), 32'd1);
`endif

    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enable_strobe_pacer.md
# enable_strobe_pacer

Upstream feeder for the enable-gated register bank. Accepts bytes on a valid/ready stream, buffers them in a small FIFO, and releases them as `out_data` with a single-cycle `out_en` strobe. The strobe spacing comes from a programmable gap. `out_data`/`out_en` connect directly to the bank's `data_in`/`enable`. Between strobes `out_data` holds its last value, so the downstream registers see no spurious activity.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `GAP_W`, default 4: width of the gap control.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream byte valid.
- `in_data` in 8: upstream byte.
- `in_ready` out 1: FIFO can accept; combinational, `= (level != DEPTH) && !flush`.
- `gap` in GAP_W: idle cycles inserted after each strobe; sampled at pop.
- `flush` in 1: synchronous clear of FIFO and pacer.
- `out_data` out 8: registered byte to the downstream bank.
- `out_en` out 1: registered one-cycle strobe, qualifies `out_data`.
- `level` out $clog2(DEPTH)+1: registered FIFO occupancy.
- `strb_cnt` out 16: strobes issued. Present only with `PACER_STRB_CNT_EN`.

## Operation
- **Push:** occurs on a clock edge where `in_valid && in_ready`. The byte is written at `wr_ptr` and `wr_ptr` increments, wrapping modulo DEPTH.
- **Pacer FSM:** two states, IDLE and GAP.
  - IDLE with `level != 0`: pop the head. Set `out_en <= 1` and `out_data <= head`.
    - If `gap == 0`, stay in IDLE. This gives back-to-back strobes, one per cycle.
    - Otherwise set `gap_cnt <= gap` and go to GAP.
  - IDLE with `level == 0`: `out_en <= 0`.
  - GAP: `out_en <= 0` and `gap_cnt` decrements each cycle. When `gap_cnt == 1`, return to IDLE.
- **Strobe spacing:** `gap + 1` cycles while data is available. A `gap` change takes effect at the next pop only.
- **Occupancy:** `level` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- **Full:** `in_ready` is 0 when `level == DEPTH`, even if a pop happens in the same cycle. There is no bypass.
- **Empty:** no pop and no strobe. `out_data` holds.
- **Flush:** highest priority. On the edge where `flush` is sampled high:
  - pointers, `level` and `gap_cnt` are cleared;
  - the state goes to IDLE and `out_en <= 0`;
  - `out_data` holds;
  - no push or pop occurs.
- **`out_data`** changes only on a strobe edge.

## Timing
- **Reset values:** `out_data = 8'h00`, `out_en = 0`, `level = 0`, `strb_cnt = 0`, state IDLE. `in_ready = 1` while `flush` is low.
- **Latency:** a byte pushed at edge k into an idle, empty FIFO appears with `out_en = 1` after edge k+1. Push-to-strobe latency is 1 cycle.
- **Reset mid-operation:** asynchronous assertion immediately forces all reset values and discards buffered data. Deassertion is synchronised externally.
- **Strobe length:** `out_en` is never high for two consecutive cycles unless `gap == 0`.

## Configuration
- **`PACER_STRB_CNT_EN` defined:** `strb_cnt` port exists.
  - Increments by 1 on every edge that sets `out_en`.
  - Wraps from 16'hFFFF to 0.
  - Cleared by reset only; not cleared by flush.
- **Undefined:** port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset then single push:** push 8'hA5 at edge 1 → `out_en = 1`, `out_data = A5` after edge 2; `out_en = 0` after edge 3; `out_data` stays A5.
- **Pacing:** `gap = 3`, push 8'h01, 8'h02, 8'h03 back-to-back → strobes exactly 4 cycles apart with data 01, 02, 03; `level` peaks at 2; with `gap = 0`, strobes occur on 3 consecutive cycles.
- **Full:** `gap = 15`, hold `in_valid` with bytes 10, 11, 12, … → `in_ready` drops when `level == 4`; no byte lost or duplicated; output order 10, 11, 12, 13, 14, ….
- **Flush mid-burst:** 3 bytes queued, `flush` pulse during GAP → `level = 0` next cycle; no further strobes; `out_data` retains the last strobed value; next push strobes 1 cycle later.
- **Async reset mid-operation:** drop `rst_n` during GAP with 2 bytes queued → outputs reset immediately; no strobe after release until a new push.
- **`PACER_STRB_CNT_EN`:** preload by issuing 65537 strobes with `gap = 0` → `strb_cnt = 1`; flush leaves it unchanged.
